// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync/filter, 11-bit deframing, odd parity, F0/E0 prefix stripping.
// Optional PS2_ASCII_EN: map set-2 make codes to ASCII, dropping unmapped and extended codes.
module ps2_kbd_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] gpi,
  output logic       gpi_we,
  output logic       rx_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  state_t                  state_q, state_d;
  logic                    clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FILTER_LEN-1:0]   hist_q, hist_d;
  logic                    filt_q, filt_d;
  logic [7:0]              shift_q, shift_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    par_q, par_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    brk_q, brk_d, ext_q, ext_d;
  logic [7:0]              gpi_q, gpi_d;
  logic                    gpi_we_q, gpi_we_d, rx_err_q, rx_err_d;
  logic                    fall, frame_ok;

`ifdef PS2_ASCII_EN
  // Returns {valid, ascii}; valid=0 for codes outside the table.
  function automatic logic [8:0] map_code(input logic [7:0] c);
    case (c)
      8'h45: map_code = {1'b1, 8'h30}; 8'h16: map_code = {1'b1, 8'h31};
      8'h1E: map_code = {1'b1, 8'h32}; 8'h26: map_code = {1'b1, 8'h33};
      8'h25: map_code = {1'b1, 8'h34}; 8'h2E: map_code = {1'b1, 8'h35};
      8'h36: map_code = {1'b1, 8'h36}; 8'h3D: map_code = {1'b1, 8'h37};
      8'h3E: map_code = {1'b1, 8'h38}; 8'h46: map_code = {1'b1, 8'h39};
      8'h1C: map_code = {1'b1, 8'h41}; 8'h32: map_code = {1'b1, 8'h42};
      8'h21: map_code = {1'b1, 8'h43}; 8'h23: map_code = {1'b1, 8'h44};
      8'h24: map_code = {1'b1, 8'h45}; 8'h2B: map_code = {1'b1, 8'h46};
      8'h34: map_code = {1'b1, 8'h47}; 8'h33: map_code = {1'b1, 8'h48};
      8'h43: map_code = {1'b1, 8'h49}; 8'h3B: map_code = {1'b1, 8'h4A};
      8'h42: map_code = {1'b1, 8'h4B}; 8'h4B: map_code = {1'b1, 8'h4C};
      8'h3A: map_code = {1'b1, 8'h4D}; 8'h31: map_code = {1'b1, 8'h4E};
      8'h44: map_code = {1'b1, 8'h4F}; 8'h4D: map_code = {1'b1, 8'h50};
      8'h15: map_code = {1'b1, 8'h51}; 8'h2D: map_code = {1'b1, 8'h52};
      8'h1B: map_code = {1'b1, 8'h53}; 8'h2C: map_code = {1'b1, 8'h54};
      8'h3C: map_code = {1'b1, 8'h55}; 8'h2A: map_code = {1'b1, 8'h56};
      8'h1D: map_code = {1'b1, 8'h57}; 8'h22: map_code = {1'b1, 8'h58};
      8'h35: map_code = {1'b1, 8'h59}; 8'h1A: map_code = {1'b1, 8'h5A};
      8'h5A: map_code = {1'b1, 8'h0D}; 8'h29: map_code = {1'b1, 8'h20};
      8'h66: map_code = {1'b1, 8'h08};
      default: map_code = {1'b0, 8'h00};
    endcase
  endfunction
  logic [8:0] mapped;
  assign mapped = map_code(shift_q);
`endif

  // Filtered clock only changes once the last FILTER_LEN samples all agree.
  always_comb begin
    hist_d = {hist_q[FILTER_LEN-2:0], clk_s2_q};
    if (&hist_q)       filt_d = 1'b1;
    else if (~|hist_q) filt_d = 1'b0;
    else               filt_d = filt_q;
  end

  assign fall     = filt_q & ~filt_d;
  assign frame_ok = dat_s2_q & (^{shift_q, par_q});

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    brk_d    = brk_q;
    ext_d    = ext_q;
    gpi_d    = gpi_q;
    gpi_we_d = 1'b0;
    rx_err_d = 1'b0;
    tmo_d    = (state_q == ST_IDLE || fall) ? '0 : tmo_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (fall && !dat_s2_q) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (!frame_ok) begin
            rx_err_d = 1'b1;
            brk_d    = 1'b0;
            ext_d    = 1'b0;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (brk_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
          end else begin
            ext_d = 1'b0;
`ifdef PS2_ASCII_EN
            if (!ext_q && mapped[8]) begin
              gpi_d    = mapped[7:0];
              gpi_we_d = 1'b1;
            end
`else
            gpi_d    = shift_q;
            gpi_we_d = 1'b1;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d  = ST_IDLE;
      rx_err_d = 1'b1;
      tmo_d    = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      hist_q   <= '1;
      filt_q   <= 1'b1;
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      gpi_q    <= '0;
      gpi_we_q <= 1'b0;
      rx_err_q <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      hist_q   <= hist_d;
      filt_q   <= filt_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      gpi_q    <= gpi_d;
      gpi_we_q <= gpi_we_d;
      rx_err_q <= rx_err_d;
    end
  end

  assign gpi    = gpi_q;
  assign gpi_we = gpi_we_q;
  assign rx_err = rx_err_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Randomized self-checking bench for ps2_kbd_rx against a frame-level keyboard model.
module tb_ps2_kbd_rx;

  localparam int FL   = 4;
  localparam int TMO  = 400;
  localparam int HALF = 20;

  logic       clock, reset, ps2_clk, ps2_data;
  logic [7:0] gpi;
  logic       gpi_we, rx_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  int         we_cnt = 0, err_cnt = 0, long_cnt = 0, both_cnt = 0;
  logic       prev_we = 1'b0;
  logic [7:0] gpi_m   = 8'h00;
  logic       brk_m   = 1'b0, ext_m = 1'b0;

  ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .gpi(gpi), .gpi_we(gpi_we), .rx_err(rx_err), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (gpi_we) we_cnt++;
    if (rx_err) err_cnt++;
    if (gpi_we && prev_we) long_cnt++;
    if (gpi_we && rx_err) both_cnt++;
    prev_we = gpi_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Key-press semantics: {valid, byte} of what a make code should produce.
  function automatic logic [8:0] key_out(input logic [7:0] b, input logic ext);
`ifdef PS2_ASCII_EN
    logic [7:0] codes [39];
    logic [7:0] ascii [39];
    codes = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,
              8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
              8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
              8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A,8'h5A,8'h29,8'h66};
    for (int i = 0; i < 10; i++) ascii[i] = 8'(8'h30 + i);
    for (int i = 0; i < 26; i++) ascii[10+i] = 8'(8'h41 + i);
    ascii[36] = 8'h0D; ascii[37] = 8'h20; ascii[38] = 8'h08;
    key_out = 9'h000;
    if (!ext)
      for (int i = 0; i < 39; i++)
        if (codes[i] == b) key_out = {1'b1, ascii[i]};
`else
    key_out = {1'b1, b};
    if (ext) key_out = {1'b1, b};
`endif
  endfunction

  task automatic model_frame(input logic [7:0] b, input logic good,
                             output int exp_we, output int exp_err);
    logic [8:0] k;
    exp_we = 0; exp_err = 0;
    if (!good) begin
      exp_err = 1; brk_m = 1'b0; ext_m = 1'b0;
    end else if (b == 8'hF0) brk_m = 1'b1;
    else if (b == 8'hE0) ext_m = 1'b1;
    else if (brk_m) begin
      brk_m = 1'b0; ext_m = 1'b0;
    end else begin
      k = key_out(b, ext_m);
      ext_m = 1'b0;
      if (k[8]) begin
        exp_we = 1; gpi_m = k[7:0];
      end
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic pe, input logic sb);
    make_frame = {sb, (~^b) ^ pe, b, 1'b0};
  endfunction

  task automatic finish_frame(input string tag, input logic [7:0] b, input logic pe,
                              input logic sb, input int lo);
    int we0, err0, ew, ee;
    we0 = we_cnt; err0 = err_cnt;
    send_bits(make_frame(b, pe, sb), lo, 10);
    ps2_data = 1'b1;
    repeat (30) @(negedge clock);
    model_frame(b, sb && !pe, ew, ee);
    check({tag, ".we"},   32'(we_cnt - we0), 32'(ew));
    check({tag, ".err"},  32'(err_cnt - err0), 32'(ee));
    check({tag, ".gpi"},  {24'h0, gpi}, {24'h0, gpi_m});
    check({tag, ".busy"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input logic pe, input logic sb);
    finish_frame(tag, b, pe, sb, 0);
  endtask

  initial begin
    logic [7:0] pick [8];
    int we0, err0, r;
    logic [7:0] b;
    pick = '{8'h1C, 8'h16, 8'h45, 8'h5A, 8'h29, 8'h66, 8'h1A, 8'h3E};

    reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clock);
    check("rst.gpi",    {24'h0, gpi}, 32'h0);
    check("rst.gpi_we", {31'h0, gpi_we}, 32'h0);
    check("rst.rx_err", {31'h0, rx_err}, 32'h0);
    check("rst.busy",   {31'h0, busy}, 32'h0);
    reset = 1'b1;
    repeat (10) @(negedge clock);

    do_frame("t1", 8'h1C, 1'b0, 1'b1);
    do_frame("t2.brk", 8'hF0, 1'b0, 1'b1);
    do_frame("t2.rel", 8'h1C, 1'b0, 1'b1);
    do_frame("t2.key", 8'h16, 1'b0, 1'b1);
    do_frame("t2.ext", 8'hE0, 1'b0, 1'b1);
    do_frame("t2.ekey", 8'h75, 1'b0, 1'b1);
    do_frame("t3.par", 8'h16, 1'b1, 1'b1);
    do_frame("t3.stop", 8'h16, 1'b0, 1'b0);

    // Timeout: start + 5 data bits then the clock stops.
    we0 = we_cnt; err0 = err_cnt;
    send_bits(make_frame(8'h45, 1'b0, 1'b1), 0, 5);
    ps2_data = 1'b1;
    repeat (100) @(negedge clock);
    check("t4.busy_mid", {31'h0, busy}, 32'h1);
    repeat (TMO + 50) @(negedge clock);
    check("t4.busy", {31'h0, busy}, 32'h0);
    check("t4.err",  32'(err_cnt - err0), 32'h1);
    check("t4.we",   32'(we_cnt - we0), 32'h0);
    do_frame("t4.next", 8'h45, 1'b0, 1'b1);

    // Spurious start (data high) is ignored silently.
    err0 = err_cnt;
    send_bits(11'h7FF, 0, 0);
    repeat (10) @(negedge clock);
    check("spur.busy", {31'h0, busy}, 32'h0);
    check("spur.err",  32'(err_cnt - err0), 32'h0);

    // Short clock glitch, then a genuine start bit.
    ps2_data = 1'b0;
    @(negedge clock);
    ps2_clk = 1'b0;
    repeat (FL - 1) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clock);
    check("t5.glitch", {31'h0, busy}, 32'h0);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clock);
    check("t5.start", {31'h0, busy}, 32'h1);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clock);
    finish_frame("t5.frame", 8'h1C, 1'b0, 1'b1, 1);

    // Reset mid-frame.
    we0 = we_cnt; err0 = err_cnt;
    send_bits(make_frame(8'h32, 1'b0, 1'b1), 0, 4);
    reset = 1'b0;
    #1;
    check("t6.gpi",  {24'h0, gpi}, 32'h0);
    check("t6.busy", {31'h0, busy}, 32'h0);
    check("t6.we",   {31'h0, gpi_we}, 32'h0);
    check("t6.err",  {31'h0, rx_err}, 32'h0);
    gpi_m = 8'h00; brk_m = 1'b0; ext_m = 1'b0;
    ps2_data = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("t6.nostrobe", 32'(we_cnt - we0 + err_cnt - err0), 32'h0);
    do_frame("t6.frame", 8'h1C, 1'b0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      b = 8'hF0;
      else if (r == 1) b = 8'hE0;
      else if (r < 6)  b = pick[$urandom_range(0, 7)];
      else             b = 8'($urandom);
      do_frame("rnd", b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0));
    end

    check("we_width",  32'(long_cnt), 32'h0);
    check("we_vs_err", 32'(both_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
